// File: rtl/mem_access_arbiter.sv
// Single-port scheduler for the unified instruction/data memory: grants at most one
// of fetch or load/store per cycle, data first, with a bounded run of data grants.
module mem_access_arbiter #(
    parameter int unsigned MAX_DATA_RUN = 2,
    parameter logic [31:0] NOP_INST     = 32'h00000033
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [2:0]  dm_funct3,
    input  logic [7:0]  dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        dm_stall,
    output logic        mem_is_inst,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [8:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_inst_in,
    input  logic [31:0] mem_data_in
);

    localparam int unsigned CNT_W = ($clog2(MAX_DATA_RUN + 1) < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_RUN);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_INST,
        GNT_DATA
    } grant_e;

    grant_e           grant;
    logic             data_req;
    logic             is_store;
    logic             at_limit;

    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [31:0]      if_inst_q, if_inst_d;
    logic             if_valid_q, if_valid_d;
    logic [31:0]      dm_rdata_q, dm_rdata_d;
    logic             dm_valid_q, dm_valid_d;

    assign data_req = dm_read | dm_write;
    assign is_store = dm_write;
    assign at_limit = (run_cnt_q == CNT_MAX);

    // Reset forces no grant, so a store caught by reset never reaches the memory.
    always_comb begin
        grant = GNT_NONE;
        if (rst) begin
            if (data_req && !(if_req && at_limit)) begin
                grant = GNT_DATA;
            end else if (if_req) begin
                grant = GNT_INST;
            end
        end
    end

    always_comb begin
        mem_is_inst = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_funct3  = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (grant)
            GNT_DATA: begin
                mem_read   = ~is_store;
                mem_write  = is_store;
                mem_funct3 = dm_funct3;
                mem_addr   = {1'b0, dm_addr};
                mem_wdata  = dm_wdata;
            end
            GNT_INST: begin
                mem_is_inst = 1'b1;
                mem_funct3  = 3'b010;
                mem_addr    = {1'b0, if_addr};
            end
            default: ;
        endcase
    end

    assign if_stall = rst & if_req & (grant != GNT_INST);
    assign dm_stall = rst & data_req & (grant != GNT_DATA);

    always_comb begin
        run_cnt_d  = run_cnt_q;
        if_inst_d  = if_inst_q;
        if_valid_d = 1'b0;
        dm_rdata_d = dm_rdata_q;
        dm_valid_d = 1'b0;

        if (!if_req || grant == GNT_INST) begin
            run_cnt_d = '0;
        end else if (grant == GNT_DATA && !at_limit) begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
        end

        if (grant == GNT_INST) begin
            if_inst_d  = mem_inst_in;
            if_valid_d = 1'b1;
        end
        if (grant == GNT_DATA) begin
            dm_valid_d = 1'b1;
            if (!is_store) begin
                dm_rdata_d = mem_data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            run_cnt_q  <= '0;
            if_inst_q  <= NOP_INST;
            if_valid_q <= 1'b0;
            dm_rdata_q <= '0;
            dm_valid_q <= 1'b0;
        end else begin
            run_cnt_q  <= run_cnt_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            dm_rdata_q <= dm_rdata_d;
            dm_valid_q <= dm_valid_d;
        end
    end

    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;
    assign dm_rdata = dm_rdata_q;
    assign dm_valid = dm_valid_q;

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Single-port access scheduler in front of the unified instruction/data memory (`SingleMem`). It takes the fetch-stage instruction request and the MEM-stage load/store request, grants at most one of them per cycle, and drives the memory's `is_inst`/`MemRead`/`MemWrite`/`funct3`/`addr`/`in` inputs. It captures the returned word into registered result outputs and stalls the loser. Data has priority, and a run-length counter bounds fetch starvation.

## Interface
- `MAX_DATA_RUN`, default 2: maximum consecutive data grants while a fetch is pending; the next grant is forced to fetch.
- `NOP_INST`, default 32'h00000033: reset/flush value of `if_inst` (`add x0, x0, x0`).

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `if_req` in 1: fetch request, held until `if_valid`.
- `if_addr` in 8: instruction byte address (PC[7:0]).
- `if_inst` out 32: registered fetched instruction.
- `if_valid` out 1: one-cycle pulse; `if_inst` is new.
- `if_stall` out 1: combinational; `if_req` not granted this cycle.
- `dm_read` in 1: load request.
- `dm_write` in 1: store request.
- `dm_funct3` in 3: load/store size code (LS_FUNCT3_B/H/W/BU/HU).
- `dm_addr` in 8: data byte address.
- `dm_wdata` in 32: store data.
- `dm_rdata` out 32: registered load result.
- `dm_valid` out 1: one-cycle pulse; load result captured or store performed.
- `dm_stall` out 1: combinational; data request not granted this cycle.
- `mem_is_inst` out 1: drives `SingleMem.is_inst`.
- `mem_read` out 1: drives `MemRead`.
- `mem_write` out 1: drives `MemWrite`.
- `mem_funct3` out 3: drives `funct3`.
- `mem_addr` out 9: drives `addr`, as {1'b0, selected 8-bit address}.
- `mem_wdata` out 32: drives `in`.
- `mem_inst_in` in 32: from `SingleMem.out`.
- `mem_data_in` in 32: from `SingleMem.mem_out`.

## Operation
- Data request = `dm_read | dm_write`. If both are high, treat it as a store only (`mem_read`=0).
- Grant decision is combinational, from the requests plus the registered counter `run_cnt`:
  - `grant_d` = data_req & ~(if_req & run_cnt == MAX_DATA_RUN).
  - `grant_i` = if_req & ~grant_d.
- Memory-side drive:
  - `grant_d`: `mem_is_inst`=0; `mem_read`/`mem_write` per request; `mem_funct3`=`dm_funct3`; `mem_addr`={0,`dm_addr`}; `mem_wdata`=`dm_wdata`.
  - `grant_i`: `mem_is_inst`=1; read/write 0; `mem_addr`={0,`if_addr`}; `mem_funct3`=3'b010.
  - No grant: all control 0, addr/wdata 0.
- `mem_write` is high only in a data-grant cycle, never in fetch or idle cycles. This is required because the memory is level-sensitive.
- Stalls: `if_stall` = `if_req` & ~`grant_i`; `dm_stall` = data_req & ~`grant_d`.
- Requesters hold address, data and funct3 stable while stalled.
- `run_cnt` (width clog2(MAX_DATA_RUN+1)), updated at the edge:
  - increments on `grant_d` when `if_req`=1, saturating at MAX_DATA_RUN;
  - clears on `grant_i`;
  - clears whenever `if_req`=0.
- Result capture at the edge:
  - `grant_i`: `if_inst`<=`mem_inst_in`, `if_valid`<=1.
  - `grant_d` with load: `dm_rdata`<=`mem_data_in`, `dm_valid`<=1.
  - `grant_d` with store: `dm_valid`<=1, `dm_rdata` holds.
  - Otherwise the valid pulses drop to 0 and the data registers hold.

## Timing
- Reset (`rst`=0 at an edge): `if_inst`=NOP_INST, `if_valid`=0, `dm_rdata`=0, `dm_valid`=0, `run_cnt`=0.
- While `rst`=0, grants are forced to 0: all `mem_*` controls 0 and both stalls 0.
- Reset asserted mid-access: the access in that cycle is discarded, nothing is captured, and no store is issued.
- Latency: request granted in cycle N, result/valid visible after edge N+1; one grant per cycle; throughput 1 access/cycle.
- Simultaneous fetch+data with run_cnt<MAX: data wins and fetch stalls. With run_cnt==MAX: fetch wins and data stalls for exactly one cycle.
- A deasserted request mid-stall is legal and is simply not served.
- Address wrap: 8-bit addresses; 8'hFF is legal and is passed through unmodified.

## Test plan
- Reset: hold `rst`=0 with `if_req`=1, `dm_write`=1 -> `mem_write`=0, `if_inst`=32'h00000033, both valids 0.
- Fetch only: `if_addr`=8'h04, `mem_inst_in`=32'h00402103 -> `mem_is_inst`=1, `mem_addr`=9'h004; next cycle `if_inst`=32'h00402103, `if_valid`=1.
- Load vs fetch conflict: `dm_read`=1, `dm_addr`=8'h08, funct3=010, `mem_data_in`=25, `if_req`=1 -> cycle 0 `if_stall`=1, `mem_is_inst`=0; then `dm_rdata`=25; fetch served the following cycle.
- Starvation bound (MAX_DATA_RUN=2): `if_req` and data requests held high for 4 cycles -> grants D,D,I,D; `if_valid` pulses exactly once, after the third cycle.
- Store: `dm_write`=1, `dm_read`=1, `dm_wdata`=32'h0000001A, `dm_addr`=8'h0C -> `mem_write`=1, `mem_read`=0 for one cycle only; `dm_valid`=1 next cycle, `dm_rdata` unchanged.
- Mid-access reset: reset pulsed during a granted store cycle -> `mem_write`=0 that cycle, no `dm_valid`.
